// File: rtl/nubus_slvbus.sv
// NuBus slave responder: decodes card-addressed cycles into memory requests.
// Optional try-again-later timeout enabled by NUBUS_SLVBUS_RETRY_EN.
module nubus_slvbus #(
  parameter bit          SUPER_EN = 1'b0,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_ad,
  output logic [31:0] slv_ad_o,
  output logic        slv_adoe_o,
  output logic        slv_ackn_o,
  output logic        slv_tm1n_o,
  output logic        slv_tm0n_o,
  output logic        slv_tmoe_o,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, WDATA, MEM, ACK
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ad_nxt, addr_nxt, wdata_nxt;
  logic [3:0]  write_nxt;
  logic        adoe_nxt, ackn_nxt;
  logic        tm1n_nxt, tm0n_nxt, tmoe_nxt;
  logic        valid_nxt;
  logic        std_hit, sup_hit, start_ok;

`ifdef NUBUS_SLVBUS_RETRY_EN
  localparam logic [7:0] WMAX = 8'(WAIT_MAX);
  logic [7:0] cnt, cnt_nxt;
`endif

  assign std_hit  = nub_ad[31:24] == {4'hF, ~nub_idn};
  assign sup_hit  = SUPER_EN && (nub_ad[31:28] == ~nub_idn);
  assign start_ok = !nub_startn && nub_ackn && (std_hit || sup_hit);

  always_comb begin
    state_nxt = state;
    ad_nxt    = slv_ad_o;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    write_nxt = mem_write;
    adoe_nxt  = 1'b0;
    ackn_nxt  = 1'b1;
    tm1n_nxt  = 1'b1;
    tm0n_nxt  = 1'b1;
    tmoe_nxt  = 1'b0;
    valid_nxt = 1'b0;
`ifdef NUBUS_SLVBUS_RETRY_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
        if (start_ok) begin
          addr_nxt = {nub_ad[31:2], 2'b00};
`ifdef NUBUS_SLVBUS_RETRY_EN
          cnt_nxt  = '0;
`endif
          unique case (1'b1)
            nub_tm1n: begin
              write_nxt = 4'b0000;
              valid_nxt = 1'b1;
              state_nxt = MEM;
            end
            !nub_tm0n: begin
              write_nxt = 4'b0001 << nub_ad[1:0];
              state_nxt = WDATA;
            end
            default: begin
              state_nxt = WDATA;
              case (nub_ad[1:0])
                2'b00:   write_nxt = 4'b1111;
                2'b01:   write_nxt = 4'b0011;
                2'b11:   write_nxt = 4'b1100;
                default: begin
                  // reserved half-word code: error without touching memory
                  write_nxt = 4'b0000;
                  state_nxt = ACK;
                  ackn_nxt  = 1'b0;
                  tmoe_nxt  = 1'b1;
                  tm0n_nxt  = 1'b0;
                end
              endcase
            end
          endcase
        end
      end
      WDATA: begin
        wdata_nxt = nub_ad;
        valid_nxt = 1'b1;
        state_nxt = MEM;
      end
      MEM: begin
        valid_nxt = 1'b1;
`ifdef NUBUS_SLVBUS_RETRY_EN
        cnt_nxt   = cnt + 8'd1;
`endif
        if (mem_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ACK;
          ackn_nxt  = 1'b0;
          tmoe_nxt  = 1'b1;
          if (mem_write == 4'b0000) begin
            ad_nxt   = mem_rdata;
            adoe_nxt = 1'b1;
          end
        end
`ifdef NUBUS_SLVBUS_RETRY_EN
        else if (cnt_nxt == WMAX) begin
          valid_nxt = 1'b0;
          state_nxt = ACK;
          ackn_nxt  = 1'b0;
          tmoe_nxt  = 1'b1;
          tm1n_nxt  = 1'b0;
          tm0n_nxt  = 1'b0;
        end
`endif
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state      <= IDLE;
      slv_ad_o   <= '0;
      slv_adoe_o <= 1'b0;
      slv_ackn_o <= 1'b1;
      slv_tm1n_o <= 1'b1;
      slv_tm0n_o <= 1'b1;
      slv_tmoe_o <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_write  <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      slv_ad_o   <= ad_nxt;
      slv_adoe_o <= adoe_nxt;
      slv_ackn_o <= ackn_nxt;
      slv_tm1n_o <= tm1n_nxt;
      slv_tm0n_o <= tm0n_nxt;
      slv_tmoe_o <= tmoe_nxt;
      mem_valid  <= valid_nxt;
      mem_addr   <= addr_nxt;
      mem_write  <= write_nxt;
      mem_wdata  <= wdata_nxt;
    end
  end

`ifdef NUBUS_SLVBUS_RETRY_EN
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) cnt <= '0;
    else             cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_nubus_slvbus.sv
// Directed bench for nubus_slvbus: read, writes, reserved code,
// ignored starts, retry/stall and reset mid-transaction.
module tb_nubus_slvbus;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  idn;
  logic        startn, ackn, tm1n, tm0n;
  logic [31:0] ad;
  logic [31:0] ad_o;
  logic        adoe, ackn_o, tm1n_o, tm0n_o, tmoe;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  nubus_slvbus #(.SUPER_EN(1'b0), .WAIT_MAX(4)) dut (
    .nub_clkn   (clk),
    .nub_resetn (resetn),
    .nub_idn    (idn),
    .nub_startn (startn),
    .nub_ackn   (ackn),
    .nub_tm1n   (tm1n),
    .nub_tm0n   (tm0n),
    .nub_ad     (ad),
    .slv_ad_o   (ad_o),
    .slv_adoe_o (adoe),
    .slv_ackn_o (ackn_o),
    .slv_tm1n_o (tm1n_o),
    .slv_tm0n_o (tm0n_o),
    .slv_tmoe_o (tmoe),
    .mem_valid  (valid),
    .mem_addr   (addr),
    .mem_write  (wr),
    .mem_wdata  (wdata),
    .mem_ready  (ready),
    .mem_rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic t1, input logic t0);
    startn = 1'b0;
    ad     = a;
    tm1n   = t1;
    tm0n   = t0;
  endtask

  task automatic idle_bus;
    startn = 1'b1;
    ackn   = 1'b1;
    tm1n   = 1'b1;
    tm0n   = 1'b1;
    ad     = '0;
  endtask

  task automatic test_reset;
    tick();
    checks++;
    if ({ackn_o, tm1n_o, tm0n_o, tmoe, adoe} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_ack got %b exp 11100",
               {ackn_o, tm1n_o, tm0n_o, tmoe, adoe});
    end
    checks++;
    if ({valid, wr} !== 5'b0 || addr !== 32'h0 || wdata !== 32'h0
        || ad_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got v=%b w=%b a=%h d=%h o=%h exp zeros",
               valid, wr, addr, wdata, ad_o);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read;
    ready = 1'b1;
    rdata = 32'hDEAD_BEEF;
    start(32'hFA00_1230, 1'b1, 1'b1);
    tick();
    idle_bus();
    checks++;
    if (valid !== 1'b1 || addr !== 32'hFA00_1230 || wr !== 4'b0000) begin
      errors++;
      $display("FAIL read_req got v=%b a=%h w=%b exp 1 fa001230 0000",
               valid, addr, wr);
    end
    checks++;
    if (ackn_o !== 1'b1) begin
      errors++;
      $display("FAIL read_early_ack got %b exp 1", ackn_o);
    end
    tick();
    checks++;
    if ({ackn_o, tmoe, tm1n_o, tm0n_o, adoe, valid} !== 6'b011110) begin
      errors++;
      $display("FAIL read_ack got %b exp 011110",
               {ackn_o, tmoe, tm1n_o, tm0n_o, adoe, valid});
    end
    checks++;
    if (ad_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_data got %h exp deadbeef", ad_o);
    end
    tick();
    checks++;
    if ({ackn_o, tmoe, adoe} !== 3'b100) begin
      errors++;
      $display("FAIL read_end got %b exp 100", {ackn_o, tmoe, adoe});
    end
  endtask

  task automatic test_write_byte;
    ready = 1'b1;
    start(32'hFA00_0042, 1'b0, 1'b0);
    tick();
    idle_bus();
    ad = 32'h00AB_0000;
    checks++;
    if (valid !== 1'b0 || wr !== 4'b0100 || addr !== 32'hFA00_0040) begin
      errors++;
      $display("FAIL wr_decode got v=%b w=%b a=%h exp 0 0100 fa000040",
               valid, wr, addr);
    end
    tick();
    ad = 32'h0;
    checks++;
    if (valid !== 1'b1 || wdata !== 32'h00AB_0000 || ackn_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_mem got v=%b d=%h k=%b exp 1 00ab0000 1",
               valid, wdata, ackn_o);
    end
    tick();
    checks++;
    if ({ackn_o, tmoe, tm1n_o, tm0n_o, adoe, valid} !== 6'b011100) begin
      errors++;
      $display("FAIL wr_ack got %b exp 011100",
               {ackn_o, tmoe, tm1n_o, tm0n_o, adoe, valid});
    end
    tick();
    checks++;
    if (ackn_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_end got %b exp 1", ackn_o);
    end
  endtask

  task automatic test_half_reserved;
    ready = 1'b1;
    start(32'hFA00_0103, 1'b0, 1'b1);
    tick();
    idle_bus();
    ad = 32'h1234_0000;
    checks++;
    if (wr !== 4'b1100) begin
      errors++;
      $display("FAIL half1_strobe got %b exp 1100", wr);
    end
    tick();
    tick();
    checks++;
    if (ackn_o !== 1'b0 || tm0n_o !== 1'b1 || wdata !== 32'h1234_0000) begin
      errors++;
      $display("FAIL half1_ack got k=%b t0=%b d=%h exp 0 1 12340000",
               ackn_o, tm0n_o, wdata);
    end
    tick();
    start(32'hFA00_0202, 1'b0, 1'b1);
    tick();
    idle_bus();
    checks++;
    if ({ackn_o, tmoe, tm1n_o, tm0n_o, valid, adoe} !== 6'b011000) begin
      errors++;
      $display("FAIL rsvd_ack got %b exp 011000",
               {ackn_o, tmoe, tm1n_o, tm0n_o, valid, adoe});
    end
    tick();
    checks++;
    if (ackn_o !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_end got k=%b v=%b exp 1 0", ackn_o, valid);
    end
  endtask

  task automatic test_ignored;
    int bad;
    bad = 0;
    start(32'hFB00_0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid !== 1'b0 || ackn_o !== 1'b1) bad++;
    end
    idle_bus();
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignore_addr got %0d bad cycles exp 0", bad);
    end
    bad = 0;
    start(32'hFA00_0000, 1'b1, 1'b1);
    ackn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid !== 1'b0 || ackn_o !== 1'b1) bad++;
    end
    idle_bus();
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignore_attn got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_stall;
    int hi;
    ready = 1'b0;
    start(32'hFA00_0010, 1'b1, 1'b1);
    tick();
    idle_bus();
    hi = 0;
`ifdef NUBUS_SLVBUS_RETRY_EN
    while (valid === 1'b1 && hi < 20) begin
      hi++;
      tick();
    end
    checks++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL retry_len got %0d exp 4", hi);
    end
    checks++;
    if ({ackn_o, tmoe, tm1n_o, tm0n_o, adoe} !== 5'b01000) begin
      errors++;
      $display("FAIL retry_ack got %b exp 01000",
               {ackn_o, tmoe, tm1n_o, tm0n_o, adoe});
    end
    tick();
    ready = 1'b1;
`else
    for (int i = 0; i < 120; i++) begin
      if (valid === 1'b1 && ackn_o === 1'b1) hi++;
      tick();
    end
    checks++;
    if (hi !== 120) begin
      errors++;
      $display("FAIL stall_hold got %0d exp 120", hi);
    end
    ready = 1'b1;
    tick();
    tick();
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    ready = 1'b0;
    rdata = 32'h5555_AAAA;
    start(32'hFA00_0080, 1'b1, 1'b1);
    tick();
    idle_bus();
    tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_valid got %b exp 1", valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ackn_o, tm1n_o, tm0n_o, tmoe, adoe, valid} !== 6'b111000
        || wr !== 4'b0 || addr !== 32'h0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got %b a=%h w=%b d=%h exp 111000 zeros",
               {ackn_o, tm1n_o, tm0n_o, tmoe, adoe, valid}, addr, wr, wdata);
    end
    tick();
    resetn = 1'b1;
    tick();
    ready = 1'b1;
    start(32'hFA00_00C4, 1'b1, 1'b1);
    tick();
    idle_bus();
    checks++;
    if (valid !== 1'b1 || addr !== 32'hFA00_00C4) begin
      errors++;
      $display("FAIL post_req got v=%b a=%h exp 1 fa0000c4", valid, addr);
    end
    tick();
    checks++;
    if (ackn_o !== 1'b0 || adoe !== 1'b1 || ad_o !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL post_ack got k=%b oe=%b d=%h exp 0 1 5555aaaa",
               ackn_o, adoe, ad_o);
    end
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    idn    = 4'b0101;
    ready  = 1'b1;
    rdata  = '0;
    idle_bus();
    test_reset();
    test_read();
    test_write_byte();
    test_half_reserved();
    test_ignored();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
